// File: rtl/adc_data_sim_pkg.sv
// Shared constants and helpers for the group-1 ADC receiver.
// Optional DAQ_VALID output is enabled by defining DAQ_VALID_EN.
package adc_data_sim_pkg;

  localparam int NCH   = 16;
  localparam int NBITS = 12;
  localparam int HW    = NBITS + 1;
  localparam int DW    = NCH * NBITS;

  localparam logic [NBITS-1:0] FRAME_PAT = 12'h03F;

  function automatic logic [NBITS-1:0] lane_slice(
    input logic [HW-1:0] h,
    input logic          off
  );
    return off ? h[HW-1:1] : h[NBITS-1:0];
  endfunction

endpackage

// File: rtl/adc_data_sim_top_lane_deser.sv
// One LVDS lane: differential receive, DDR capture, 13-bit history.
// Pairs enter the history oldest-first: fall bit at [11], rise at [12].
module adc_lane_deser
  import adc_data_sim_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          pad_p,
  input  logic          pad_n,
  output logic [HW-1:0] hist
);

  logic d;
  logic fall;
  logic fall_r;
  logic rise;

  assign d = pad_p & ~pad_n;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) fall <= 1'b0;
    else     fall <= d;
  end

  // fall_r holds the falling-edge bit that precedes the rise bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise   <= 1'b0;
      fall_r <= 1'b0;
      hist   <= '0;
    end else begin
      rise   <= d;
      fall_r <= fall;
      hist   <= {rise, fall_r, hist[HW-1:2]};
    end
  end

endmodule

// File: rtl/adc_data_sim_top.sv
// Group-1 ADC receiver: 16 data lanes + frame lane, word alignment.
// Define DAQ_VALID_EN to add the DAQ_VALID update strobe.
module adc_data_sim_top
  import adc_data_sim_pkg::*;
(
  input  logic           G1LCLK0P,
  input  logic           G1LCLK0N,
  input  logic           RST,
  input  logic           ALTXO_CLK_AC_P,
  input  logic           ALTXO_CLK_AC_N,
  input  logic           G1ADCLK0P,
  input  logic           G1ADCLK0N,
  input  logic [NCH-1:0] G1AD_P,
  input  logic [NCH-1:0] G1AD_N,
  output logic [DW-1:0]  G1DAQ16CH
`ifdef DAQ_VALID_EN
  ,
  output logic           DAQ_VALID
`endif
);

  logic          lclk;
  logic          unused_pins;
  logic [HW-1:0] fhist;
  logic [HW-1:0] hist [NCH];
  logic          m0;
  logic          m1;
  logic          match;
  logic          off_sel;
  logic [DW-1:0] slices;
  logic [DW-1:0] slice_q;
  logic          det_q;
  logic          offset_q;

  assign lclk        = G1LCLK0P;
  assign unused_pins = ^{ALTXO_CLK_AC_P, ALTXO_CLK_AC_N, G1LCLK0N};

  adc_lane_deser u_frame (
    .clk   (lclk),
    .rst   (RST),
    .pad_p (G1ADCLK0P),
    .pad_n (G1ADCLK0N),
    .hist  (fhist)
  );

  for (genvar ch = 0; ch < NCH; ch++) begin : g_lane
    adc_lane_deser u_lane (
      .clk   (lclk),
      .rst   (RST),
      .pad_p (G1AD_P[ch]),
      .pad_n (G1AD_N[ch]),
      .hist  (hist[ch])
    );
  end

  assign m0      = (fhist[NBITS-1:0] == FRAME_PAT);
  assign m1      = (fhist[HW-1:1] == FRAME_PAT);
  assign match   = m0 | m1;
  assign off_sel = ~m0;

  always_comb begin
    slices = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      slices[ch*NBITS +: NBITS] =
        lane_slice(hist[ch], off_sel);
    end
  end

  // slices are frozen at the detect edge, published one edge later
  always_ff @(posedge lclk or posedge RST) begin
    if (RST) begin
      det_q     <= 1'b0;
      offset_q  <= 1'b0;
      slice_q   <= '0;
      G1DAQ16CH <= '0;
    end else begin
      det_q <= match;
      if (match) begin
        offset_q <= off_sel;
        slice_q  <= slices;
      end
      if (det_q) G1DAQ16CH <= slice_q;
    end
  end

`ifdef DAQ_VALID_EN
  always_ff @(posedge lclk or posedge RST) begin
    if (RST) DAQ_VALID <= 1'b0;
    else     DAQ_VALID <= det_q;
  end
`endif

endmodule

// File: tb/tb_adc_data_sim_top.sv
// Randomized bench for adc_data_sim_top against a frame-level model.
// Define DAQ_VALID_EN to also check the DAQ_VALID strobe.
module tb_adc_data_sim_top;

  localparam int NCH = 16;
  localparam int NB  = 12;
  localparam int DW  = NCH * NB;
  localparam int LAT = 48;

  typedef struct {
    logic [DW-1:0] w;
    time           ts;
    string         tag;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           fr;
  logic [NCH-1:0] ad;
  logic [DW-1:0]  daq;
`ifdef DAQ_VALID_EN
  logic           valid;
`endif

  int            n_cmp;
  int            n_bad;
  exp_t          q[$];
  logic [DW-1:0] prev;
  logic [DW-1:0] last_exp;

  adc_data_sim_top dut (
    .G1LCLK0P       (clk),
    .G1LCLK0N       (~clk),
    .RST            (rst),
    .ALTXO_CLK_AC_P (1'b0),
    .ALTXO_CLK_AC_N (1'b1),
    .G1ADCLK0P      (fr),
    .G1ADCLK0N      (~fr),
    .G1AD_P         (ad),
    .G1AD_N         (~ad),
    .G1DAQ16CH      (daq)
`ifdef DAQ_VALID_EN
    ,
    .DAQ_VALID      (valid)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  task automatic check(
    input string         tag,
    input logic [DW-1:0] got,
    input logic [DW-1:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Output monitor: every change of G1DAQ16CH must be the next
  // expected frame word, delivered within LAT ns of its last bit.
  always @(negedge clk) begin
    logic chg;
    chg = 1'b0;
    if (rst) begin
      check("rst_zero", daq, '0);
      q.delete();
      prev = '0;
    end else begin
      if (daq !== prev) begin
        chg = 1'b1;
        if (q.size() == 0) begin
          check("spurious", daq, prev);
        end else begin
          check(q[0].tag, daq, q[0].w);
          void'(q.pop_front());
        end
        prev = daq;
      end
`ifdef DAQ_VALID_EN
      check("valid", {191'd0, valid}, {191'd0, chg});
`endif
      if (q.size() != 0 && ($time - q[0].ts) > LAT) begin
        check({q[0].tag, "_late"}, daq, q[0].w);
        void'(q.pop_front());
      end
    end
  end

  task automatic send_frame(
    input logic [DW-1:0] w,
    input bit            fr_on,
    input bit            push,
    input string         tag
  );
    exp_t e;
    for (int b = 0; b < NB; b++) begin
      for (int ch = 0; ch < NCH; ch++) ad[ch] = w[ch*NB + b];
      fr = fr_on && (b < 6);
      if (b == NB - 1 && push) begin
        e.w   = w;
        e.ts  = $time;
        e.tag = tag;
        q.push_back(e);
        last_exp = w;
      end
      #4;
    end
  endtask

  task automatic new_word(output logic [DW-1:0] w);
    do begin
      for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    end while (w == last_exp);
  endtask

  task automatic rand_frames(input int n, input string tag);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      new_word(w);
      send_frame(w, 1'b1, 1'b1, tag);
    end
  endtask

  task automatic alt_frames(input int n, input string tag);
    logic [DW-1:0] wa;
    logic [DW-1:0] wb;
    wa = {NCH{12'h106}};
    wb = {NCH{12'hC59}};
    for (int i = 0; i < n; i++) begin
      if (last_exp == wa) send_frame(wb, 1'b1, 1'b1, tag);
      else                send_frame(wa, 1'b1, 1'b1, tag);
    end
  endtask

  logic [DW-1:0] w;

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    prev     = '0;
    last_exp = '0;
    rst      = 1'b1;
    fr       = 1'b0;
    ad       = '0;
    #200;
    rst = 1'b0;
    @(negedge clk);
    #2;

    alt_frames(4, "alt");
    for (int ch = 0; ch < NCH; ch++) w[ch*NB +: NB] = 12'h100 + 12'(ch);
    send_frame(w, 1'b1, 1'b1, "perch");
    alt_frames(1, "alt2");
    rand_frames(4, "rand");
    check("offset_even", {191'd0, dut.offset_q}, '0);

    new_word(w);
    send_frame(w, 1'b0, 1'b0, "");
    rand_frames(2, "post_glitch");

    fork
      begin
        rst = 1'b1;
        #1 check("rst_now", daq, '0);
        #19 rst = 1'b0;
      end
    join_none
    last_exp = '0;
    new_word(w);
    send_frame(w, 1'b1, 1'b0, "");
    rand_frames(3, "relock");

    ad = '0;
    fr = 1'b0;
    #4;
    alt_frames(4, "odd_alt");
    check("offset_odd", {191'd0, dut.offset_q}, {191'd0, 1'b1});
    rand_frames(3, "odd_rand");

    for (int i = 0; i < 3; i++) send_frame('0, 1'b0, 1'b0, "");
    check("drained", DW'(q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
